// File: rtl/uart_tx_fifo.sv
// Buffered UART transmitter: power-of-two FIFO feeding a start/data/parity/stop serialiser.
// A word pushed into an idle, empty block starts its start bit one cycle later; in_ready drops while the FIFO is full.
module uart_tx_fifo #(
  parameter int CLOCKS_PER_BIT = 4,
  parameter int DATA_BITS      = 8,
  parameter int PARITY         = 0,
  parameter int STOP_BITS      = 1,
  parameter int DEPTH          = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [DATA_BITS-1:0]     in_data,
  input  logic                     in_valid,
  output logic                     in_ready,
  output logic                     out_tx,
  output logic                     out_busy,
  output logic [$clog2(DEPTH):0]   out_count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(CLOCKS_PER_BIT);
  localparam int BW = 4;

  typedef enum logic [2:0] {IDLE, START, DATA, PAR, STOP} state_t;

  logic [DATA_BITS-1:0] mem [DEPTH];
  logic [AW-1:0]        wr_ptr, rd_ptr;
  logic [AW:0]          count;

  state_t               state, state_nxt;
  logic [CW-1:0]        cyc_cnt, cyc_nxt;
  logic [BW-1:0]        bit_cnt, bit_nxt;
  logic [DATA_BITS-1:0] shift_q, shift_nxt;
  logic                 par_q, par_nxt;
  logic                 tx_nxt;

  logic push, pop, bit_end, last_stop;

  assign in_ready  = count < (AW+1)'(DEPTH);
  assign push      = in_valid && in_ready;
  assign bit_end   = cyc_cnt == CW'(CLOCKS_PER_BIT - 1);
  assign last_stop = (state == STOP) && bit_end && (bit_cnt == BW'(STOP_BITS - 1));
  // Loading at the last stop cycle is what makes frames run back-to-back.
  assign pop       = ((state == IDLE) || last_stop) && (count != '0);

  assign out_busy  = state != IDLE;
  assign out_count = count;

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= in_data;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      if (push && !pop)      count <= count + (AW+1)'(1);
      else if (!push && pop) count <= count - (AW+1)'(1);
    end
  end

  always_comb begin
    state_nxt = state;
    cyc_nxt   = cyc_cnt;
    bit_nxt   = bit_cnt;
    shift_nxt = shift_q;
    par_nxt   = par_q;
    tx_nxt    = 1'b1;

    if (state != IDLE) cyc_nxt = bit_end ? '0 : cyc_cnt + CW'(1);

    unique case (state)
      IDLE: ;
      START: begin
        if (bit_end) begin
          state_nxt = DATA;
          bit_nxt   = '0;
        end
      end
      DATA: begin
        if (bit_end) begin
          if (bit_cnt == BW'(DATA_BITS - 1)) begin
            state_nxt = (PARITY != 0) ? PAR : STOP;
            bit_nxt   = '0;
          end else begin
            bit_nxt   = bit_cnt + BW'(1);
            shift_nxt = shift_q >> 1;
          end
        end
      end
      PAR: begin
        if (bit_end) begin
          state_nxt = STOP;
          bit_nxt   = '0;
        end
      end
      STOP: begin
        if (bit_end) begin
          if (bit_cnt == BW'(STOP_BITS - 1)) state_nxt = IDLE;
          else                                bit_nxt   = bit_cnt + BW'(1);
        end
      end
      default: state_nxt = IDLE;
    endcase

    // Parity is captured from the word as it is loaded, not from the shifting copy.
    if (pop) begin
      state_nxt = START;
      cyc_nxt   = '0;
      bit_nxt   = '0;
      shift_nxt = mem[rd_ptr];
      par_nxt   = (^mem[rd_ptr]) ^ (PARITY == 2);
    end

    unique case (state_nxt)
      START:   tx_nxt = 1'b0;
      DATA:    tx_nxt = shift_nxt[0];
      PAR:     tx_nxt = par_nxt;
      default: tx_nxt = 1'b1;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      cyc_cnt <= '0;
      bit_cnt <= '0;
      shift_q <= '0;
      par_q   <= 1'b0;
      out_tx  <= 1'b1;
    end else begin
      state   <= state_nxt;
      cyc_cnt <= cyc_nxt;
      bit_cnt <= bit_nxt;
      shift_q <= shift_nxt;
      par_q   <= par_nxt;
      out_tx  <= tx_nxt;
    end
  end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Drives three differently configured transmitters with shared stimulus and compares
// every output each cycle against a queue-based line model.
module tb_uart_tx_fifo;

  logic            clk = 1'b0;
  logic            rst;
  logic            stim_vld;
  logic [8:0]      stim_data;
  logic [2:0]      tx_a, busy_a, rdy_a;
  logic [2:0][4:0] cnt_a;
  bit              chk_en = 1'b0;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  function automatic int cfg_cpb(int g); return (g == 2) ? 3 : 4;  endfunction
  function automatic int cfg_dw (int g); return (g == 2) ? 9 : 8;  endfunction
  function automatic int cfg_par(int g); return g;                 endfunction
  function automatic int cfg_stp(int g); return (g == 1) ? 2 : 1;  endfunction
  function automatic int cfg_dep(int g); return (g == 2) ? 4 : 16; endfunction
  function automatic int frame_len(int g);
    return cfg_cpb(g) * (1 + cfg_dw(g) + ((cfg_par(g) != 0) ? 1 : 0) + cfg_stp(g));
  endfunction

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  for (genvar g = 0; g < 3; g++) begin : g_inst
    localparam int CPB = cfg_cpb(g);
    localparam int DW  = cfg_dw(g);
    localparam int PAR = cfg_par(g);
    localparam int STP = cfg_stp(g);
    localparam int DEP = cfg_dep(g);
    localparam int AW  = $clog2(DEP);

    logic        tx_w, busy_w, rdy_w;
    logic [AW:0] cnt_w;

    uart_tx_fifo #(
      .CLOCKS_PER_BIT(CPB), .DATA_BITS(DW), .PARITY(PAR), .STOP_BITS(STP), .DEPTH(DEP)
    ) dut (
      .clk      (clk),
      .reset    (rst),
      .in_data  (stim_data[DW-1:0]),
      .in_valid (stim_vld),
      .in_ready (rdy_w),
      .out_tx   (tx_w),
      .out_busy (busy_w),
      .out_count(cnt_w)
    );

    assign tx_a[g]   = tx_w;
    assign busy_a[g] = busy_w;
    assign rdy_a[g]  = rdy_w;
    assign cnt_a[g]  = 5'(cnt_w);

    // Model: words waiting, plus the line level expected for each upcoming cycle.
    int fifo_q[$];
    bit line_q[$];
    int w, ones;
    bit do_push, do_pop, pbit;

    always @(posedge clk or posedge rst) begin
      if (rst) begin
        fifo_q.delete();
        line_q.delete();
      end else begin
        do_push = stim_vld && (fifo_q.size() < DEP);
        do_pop  = (fifo_q.size() != 0) && (line_q.size() <= 1);
        if (line_q.size() > 0) void'(line_q.pop_front());
        if (do_pop) begin
          w = fifo_q.pop_front();
          ones = 0;
          for (int i = 0; i < DW; i++) ones += (w >> i) & 1;
          for (int k = 0; k < CPB; k++) line_q.push_back(1'b0);
          for (int i = 0; i < DW; i++)
            for (int k = 0; k < CPB; k++) line_q.push_back(bit'((w >> i) & 1));
          if (PAR != 0) begin
            pbit = (ones % 2 == 1) ^ (PAR == 2);
            for (int k = 0; k < CPB; k++) line_q.push_back(pbit);
          end
          for (int k = 0; k < STP * CPB; k++) line_q.push_back(1'b1);
        end
        if (do_push) fifo_q.push_back(int'(stim_data) & ((1 << DW) - 1));
      end
    end

    always @(negedge clk) begin
      if (chk_en) begin
        check($sformatf("tx[%0d]", g),    int'(tx_w),   (line_q.size() > 0) ? int'(line_q[0]) : 1);
        check($sformatf("busy[%0d]", g),  int'(busy_w), (line_q.size() > 0) ? 1 : 0);
        check($sformatf("count[%0d]", g), int'(cnt_w),  fifo_q.size());
        check($sformatf("ready[%0d]", g), int'(rdy_w),  (fifo_q.size() < DEP) ? 1 : 0);
      end
    end
  end

  task automatic push_word(input logic [8:0] d);
    stim_data = d;
    stim_vld  = 1'b1;
    @(negedge clk);
    stim_vld  = 1'b0;
  endtask

  task automatic measure_frames(input string tag);
    int bc[3];
    bc = '{0, 0, 0};
    repeat (60) begin
      @(negedge clk);
      for (int g = 0; g < 3; g++) bc[g] += int'(busy_a[g]);
    end
    for (int g = 0; g < 3; g++) check($sformatf("%s_len[%0d]", tag, g), bc[g], frame_len(g));
  endtask

  initial begin
    int  acc[3];
    bit  fell[3];

    rst = 1'b1;
    stim_vld = 1'b0;
    stim_data = '0;
    chk_en = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (100) @(negedge clk);

    push_word(9'h0A5);
    measure_frames("a5");
    push_word(9'h007);
    measure_frames("07");

    push_word(9'h000);
    push_word(9'h0FF);
    repeat (120) @(negedge clk);

    // Fill from idle with incrementing data, then watch one accept per frame.
    acc = '{0, 0, 0};
    fell = '{0, 0, 0};
    stim_vld = 1'b1;
    for (int c = 0; c < 30; c++) begin
      for (int g = 0; g < 3; g++)
        if (!fell[g]) begin
          if (rdy_a[g]) acc[g]++;
          else          fell[g] = 1'b1;
        end
      @(negedge clk);
      stim_data = stim_data + 9'd1;
    end
    for (int g = 0; g < 3; g++) check($sformatf("fill_accepts[%0d]", g), acc[g], cfg_dep(g) + 1);
    acc = '{0, 0, 0};
    for (int c = 0; c < 720; c++) begin
      for (int g = 0; g < 3; g++) acc[g] += int'(rdy_a[g]);
      @(negedge clk);
      stim_data = stim_data + 9'd1;
    end
    for (int g = 0; g < 3; g++) check($sformatf("steady_accepts[%0d]", g), acc[g], 720 / frame_len(g));
    stim_vld = 1'b0;
    repeat (900) @(negedge clk);

    repeat (3000) begin
      stim_vld  = ($urandom_range(0, 3) == 0);
      stim_data = 9'($urandom);
      @(negedge clk);
    end
    stim_vld = 1'b0;
    repeat (900) @(negedge clk);

    // Reset in the middle of a frame with words still queued.
    repeat (4) begin
      stim_vld  = 1'b1;
      stim_data = 9'($urandom);
      @(negedge clk);
    end
    stim_vld = 1'b0;
    repeat (14) @(negedge clk);
    @(posedge clk);
    #2;
    check("pre_rst_busy", int'(busy_a[0]), 1);
    check("pre_rst_count", int'(cnt_a[0]), 3);
    rst = 1'b1;
    #1;
    check("rst_async_tx", int'(tx_a), 7);
    check("rst_async_busy", int'(busy_a), 0);
    check("rst_async_count0", int'(cnt_a[0]), 0);
    check("rst_async_ready", int'(rdy_a), 7);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (50) @(negedge clk);
    push_word(9'h13C);
    repeat (60) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
